// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and types.
package cpu_pkg;
    localparam int ADDR_W  = 64;
    localparam int INST_W  = 32;
    localparam int PC_INCR = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush wins over push/pop; the head entry is read combinationally.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC, issues in-order fetches under a credit limit,
// tags returned instructions with their PC and hands them to decode.
// A redirect reloads the PC, flushes the buffer and drops in-flight responses.
module pc_fetch_unit #(
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int INST_W    = cpu_pkg::INST_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] startPC,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              misalign
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

    fetch_state_t       state, state_nxt;
    logic [ADDR_W-1:0]  pc, rsp_pc, tgt_pc;
    logic [CNT_W-1:0]   outstanding, drop_cnt, occ;
    logic               run_redirect, credit_ok;
    logic               req_fire, rsp_fire, rsp_keep;
    logic               fifo_full, fifo_empty;
    logic [INST_W+ADDR_W-1:0] head;

    // In-flight plus buffered entries may never exceed the buffer size.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, occ}) < (CNT_W + 1)'(BUF_DEPTH);
    assign tgt_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Next state and request/redirect qualification; BOOT ignores redirect.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        run_redirect   = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                run_redirect   = redirect;
                imem_req_valid = !redirect && credit_ok && !fifo_full;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign imem_req_addr = pc;
    assign req_fire      = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire      = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep      = rsp_fire && (drop_cnt == '0) && !run_redirect;

    // State register.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) state <= BOOT;
        else          state <= state_nxt;
    end

    // PC, response tag, credit and drop bookkeeping.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc          <= '0;
            rsp_pc      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            misalign    <= 1'b0;
        end else begin
            misalign <= run_redirect && (redirect_pc[1:0] != 2'b00);
            case ({req_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (state == BOOT) begin
                pc     <= startPC;
                rsp_pc <= startPC;
            end else if (run_redirect) begin
                // This cycle's response is counted out here, so it is dropped too.
                pc       <= tgt_pc;
                rsp_pc   <= tgt_pc;
                drop_cnt <= outstanding - CNT_W'(rsp_fire);
            end else begin
                if (req_fire) pc <= pc + INCR;
                if (rsp_fire) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                    else                rsp_pc   <= rsp_pc + INCR;
                end
            end
        end
    end

    inst_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (INST_W + ADDR_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .flush     (run_redirect),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, rsp_pc}),
        .pop       (inst_ready),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occ)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = head[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc    = head[ADDR_W-1:0];
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory responses are driven by hand each cycle.
module tb_pc_fetch_unit;
    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] startPC;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        misalign;

    int n_chk  = 0;
    int n_fail = 0;

    pc_fetch_unit dut (
        .CLK            (CLK),
        .Reset_L        (Reset_L),
        .startPC        (startPC),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .misalign       (misalign)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [63:0] rpc, input logic rdy,
                         input logic rv, input logic [31:0] rdat, input logic ir);
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdat;
        inst_ready     = ir;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [63:0] a);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'(v));
        if (v) chk({tag, "_req_addr"}, imem_req_addr, a);
    endtask

    task automatic chk_inst(input string tag, input logic v, input logic [63:0] p, input logic [31:0] d);
        chk({tag, "_inst_valid"}, 64'(inst_valid), 64'(v));
        if (v) begin
            chk({tag, "_inst_pc"}, inst_pc, p);
            chk({tag, "_inst_data"}, 64'(inst_data), 64'(d));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        chk({tag, "_req_addr"},  imem_req_addr,       64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid),    64'd0);
        chk({tag, "_inst_data"}, 64'(inst_data),      64'd0);
        chk({tag, "_inst_pc"},   inst_pc,             64'd0);
        chk({tag, "_misalign"},  64'(misalign),       64'd0);
    endtask

    initial begin
        Reset_L = 1'b0;
        startPC = 64'h400;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk_all_zero("reset");
        tick(); tick();

        // Boot: no request in BOOT, then 0x400, 0x404, bubble, 0x408
        Reset_L = 1'b1;
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("boot", 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("run0", 1, 64'h400);
        tick();
        drive(0, 0, 1, 1, 32'hA000_0400, 1);
        #3 chk_req("run1", 1, 64'h404);
        chk_inst("run1", 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hA000_0404, 1);
        #3 chk_req("credit_full", 0, 0);
        chk_inst("run2", 1, 64'h400, 32'hA000_0400);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("run3", 1, 64'h408);
        chk_inst("run3", 1, 64'h404, 32'hA000_0404);
        tick();

        // Backpressure: decode stalls, buffer fills, requests stop
        drive(0, 0, 1, 1, 32'hA000_0408, 0);
        #3 chk_req("bp0", 1, 64'h40C);
        chk_inst("bp0", 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hA000_040C, 0);
        #3 chk_req("bp1", 0, 0);
        chk_inst("bp1", 1, 64'h408, 32'hA000_0408);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        #3 chk_req("bp2", 0, 0);
        chk_inst("bp2", 1, 64'h408, 32'hA000_0408);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        #3 chk_req("bp3", 0, 0);
        chk_inst("bp3", 1, 64'h408, 32'hA000_0408);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("bp_rel", 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("resume0", 1, 64'h410);
        chk_inst("resume0", 1, 64'h40C, 32'hA000_040C);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("resume1", 1, 64'h414);
        chk_inst("resume1", 0, 0, 0);
        tick();

        // Redirect with two in flight: no request this cycle, both stale responses dropped
        drive(1, 64'h1000, 1, 0, 0, 1);
        #3 chk_req("redir2", 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
        #3 chk_req("drop0", 0, 0);
        chk_inst("drop0", 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hDEAD_BEE0, 1);
        #3 chk_req("drop1", 1, 64'h1000);
        chk_inst("drop1", 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 32'hB000_1000, 1);
        #3 chk_inst("drop2", 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #3 chk_inst("after_redir", 1, 64'h1000, 32'hB000_1000);
        tick();

        // Redirect coinciding with the only outstanding response
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("pre_same", 1, 64'h1004);
        tick();
        drive(1, 64'h3000, 1, 1, 32'h0BAD_BAD0, 1);
        #3 chk_req("redir_same", 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("same0", 1, 64'h3000);
        chk_inst("same0", 0, 0, 0);
        chk("same0_misalign", 64'(misalign), 64'd0);
        tick();
        drive(0, 0, 0, 1, 32'hC000_3000, 1);
        #3;
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #3 chk_inst("same1", 1, 64'h3000, 32'hC000_3000);
        tick();

        // Misaligned redirect: one-cycle pulse, fetch aligned down
        drive(1, 64'h2002, 1, 0, 0, 1);
        #3 chk_req("mis_redir", 0, 0);
        chk("mis_pre", 64'(misalign), 64'd0);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk("mis_pulse", 64'(misalign), 64'd1);
        chk_req("mis0", 1, 64'h2000);
        tick();
        drive(0, 0, 0, 1, 32'hD000_2000, 1);
        #3 chk("mis_end", 64'(misalign), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #3 chk_inst("mis1", 1, 64'h2000, 32'hD000_2000);

        // Asynchronous reset between edges
        #1 Reset_L = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();

        // Restart from a new startPC; stray response and redirect in BOOT are ignored
        Reset_L = 1'b1;
        startPC = 64'h800;
        drive(1, 64'h5001, 1, 1, 32'hFFFF_FFFF, 1);
        #3 chk_req("reboot", 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #3 chk_req("reboot0", 1, 64'h800);
        chk_inst("reboot0", 0, 0, 0);
        chk("reboot0_misalign", 64'(misalign), 64'd0);
        tick();
        drive(0, 0, 1, 1, 32'hE000_0800, 1);
        #3 chk_req("reboot1", 1, 64'h804);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #3 chk_inst("reboot2", 1, 64'h800, 32'hE000_0800);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential consumer of the NextPC value produced by the next-PC logic.
- Owns the architectural PC register and issues in-order instruction fetches to instruction memory over a request/response interface.
- Buffers returned instructions and presents them to decode with a valid/ready handshake.
- On a branch redirect, loads the new PC, flushes buffered instructions and discards in-flight responses.

Parameters:
- ADDR_W, 64, PC/address width.
- INST_W, 32, instruction width.
- BUF_DEPTH, 2, instruction buffer entries; also the maximum in-flight-plus-buffered credit.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- Reset_L  input  1  reset, asynchronous assertion, active-low.
- startPC  input  ADDR_W  boot PC, sampled in the BOOT state.
- redirect  input  1  taken branch; load redirect_pc this cycle.
- redirect_pc  input  ADDR_W  target PC (NextPC).
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  ADDR_W  fetch address (equals pc).
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response returned; in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  INST_W  returned instruction.
- inst_valid  output  1  buffer head valid.
- inst_data  output  INST_W  head instruction.
- inst_pc  output  ADDR_W  PC of the head instruction.
- inst_ready  input  1  decode consumes the head.
- misalign  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (Reset_L=0, asynchronous):
  - state=BOOT; pc=0; rsp_pc=0.
  - outstanding=0; drop_cnt=0; buffer empty.
  - All outputs 0.
- BOOT (one cycle): pc<=startPC, rsp_pc<=startPC, then RUN. No request is issued in BOOT.
- RUN, request issue:
  - imem_req_valid = !redirect && (outstanding + occupancy < BUF_DEPTH).
  - imem_req_valid is combinational and may drop without acceptance; the memory treats only valid&&ready as a transfer.
  - On accept: pc<=pc+4 (64-bit wrap, no overflow flag); outstanding+1.
- Response:
  - Every imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: push {imem_rsp_data, rsp_pc} into the buffer and set rsp_pc<=rsp_pc+4.
  - The buffer cannot overflow, by the credit rule. A response arriving with outstanding==0 is a protocol error; it is ignored.
- Decode:
  - inst_valid = buffer non-empty; inst_data/inst_pc come from the head.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle on a full buffer is legal; occupancy is unchanged.
- Redirect (RUN, redirect=1), highest priority:
  - pc<=rsp_pc<={redirect_pc[ADDR_W-1:2],2'b00}.
  - Buffer flushed (occupancy<=0).
  - drop_cnt<=outstanding − imem_rsp_valid; this cycle's response is itself dropped.
  - No request issued this cycle; any pop this cycle is discarded together with the flush.
  - misalign<=1 for one cycle if redirect_pc[1:0]!=0.
- Redirect during BOOT: ignored.
- Back-to-back redirects: the second recomputes drop_cnt from the current outstanding.
- Reset mid-operation: immediate return to reset values; any later stray response is ignored because outstanding==0.
- Latency:
  - First request is issued 1 cycle after reset release (BOOT), then every cycle while credit remains.
  - Instruction is visible on inst_valid the cycle after the response.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, INST_W.
  - PC_INCR=4.
  - Fetch state enum {BOOT, RUN}.
- One sub-module: inst_fifo, a BUF_DEPTH×(INST_W+ADDR_W) synchronous FIFO with flush, full/empty and occupancy outputs.

Test Plan:
- Boot: startPC=0x400, Reset_L released, imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> requests at 0x400, 0x404, 0x408; inst_pc sequence 0x400, 0x404, … each with the matching data.
- Backpressure: inst_ready=0 -> at most 2 requests total, inst_valid held on 0x400; release inst_ready -> fetch resumes at 0x408.
- Redirect with 2 in flight: redirect_pc=0x1000 while outstanding=2 -> both stale responses dropped; next inst_pc=0x1000; no request issued in the redirect cycle.
- Redirect in the same cycle as a response: outstanding=1, imem_rsp_valid=1 -> drop_cnt=0, response discarded; next accepted response tagged redirect_pc.
- Misaligned redirect: redirect_pc=0x2002 -> misalign pulses 1 cycle; fetch address 0x2000.
- Async reset mid-stream: Reset_L=0 between clock edges -> all outputs 0 immediately; after release, refetch from startPC.
